seg7_sniffer: RTL and testbench

SEG7_SNIFFER -- requirements
Module: seg7_sniffer

---
 rtl/seg7_pkg.sv | 48 ++++
 rtl/seg7_sniffer_if.sv | 22 ++
 rtl/seg7_evfifo.sv | 46 ++++
 rtl/seg7_sniffer.sv | 139 +++++++++++++
 tb/tb_seg7_sniffer.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment display sniffer.
// The hex digits 8..F are only treated as legal when SEG7_HEX_EN is defined.
package seg7_pkg;

  localparam int SEG_W   = 7;
  localparam int IDX_W   = 3;
  localparam int CODE_W  = 4;
  localparam int MAX_DIG = 8;

  // Active-low patterns, bit6 = a ... bit0 = g
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;
  localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B     = 7'b1100000;
  localparam logic [SEG_W-1:0] SEG_C     = 7'b0110001;
  localparam logic [SEG_W-1:0] SEG_D     = 7'b1000010;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_F     = 7'b0111000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_LOCKED
  } state_t;

  typedef struct packed {
    logic              on;
    logic [CODE_W-1:0] code;
    logic              err;
  } digit_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    digit_t           d;
  } event_t;

  localparam int EV_W = $bits(event_t);

endpackage

// File: rtl/seg7_sniffer_if.sv
// Change-event stream from the sniffer: valid/ready handshake plus the event fields.
interface seg7_sniffer_if;
  import seg7_pkg::*;

  logic              ev_valid;
  logic              ev_ready;
  logic [IDX_W-1:0]  ev_idx;
  logic              ev_on;
  logic [CODE_W-1:0] ev_code;
  logic              ev_err;

  modport master (
    output ev_valid, ev_idx, ev_on, ev_code, ev_err,
    input  ev_ready
  );

  modport slave (
    input  ev_valid, ev_idx, ev_on, ev_code, ev_err,
    output ev_ready
  );

endinterface

// File: rtl/seg7_evfifo.sv
// Small event FIFO; the head reads as zero while empty so idle outputs stay quiet.
module seg7_evfifo #(
  parameter int DEPTH = 4,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  // Extra pointer MSB distinguishes full from empty when the addresses match
  assign valid   = (wptr != rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign dout    = valid ? mem[rptr[AW-1:0]] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + ONE;
      if (do_pop)  rptr <= rptr + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/seg7_sniffer.sv
// Watches a multiplexed 7-segment bus, debounces each digit and reports value changes.
// Define SEG7_HEX_EN to also accept the hex glyphs 8..F as legal digits.
module seg7_sniffer
  import seg7_pkg::*;
#(
  parameter int NDIG       = 8,
  parameter int STABLE_CYC = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [6:0]      seg_n,
  input  logic [NDIG-1:0] an_n,
  seg7_sniffer_if.master  ev,
  output logic            ovf
);

  logic [SEG_W+NDIG-1:0] cur;
  logic [SEG_W+NDIG-1:0] prev;
  state_t                state;
  state_t                state_n;
  logic [7:0]            cnt;
  logic [7:0]            cnt_n;
  logic                  sel_valid;
  logic                  same;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic [IDX_W-1:0]      sel_idx;
  digit_t                dec;
  digit_t                shadow [MAX_DIG];
  event_t                ev_in;
  event_t                ev_out;

  assign cur       = {seg_n, an_n};
  assign sel_valid = $onehot(~an_n);
  assign same      = (cur == prev);

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (!an_n[i]) sel_idx = IDX_W'(i);
    end
  end

  always_comb begin
    dec.on   = 1'b1;
    dec.code = '0;
    dec.err  = 1'b0;
    case (seg_n)
      SEG_BLANK: dec.on   = 1'b0;
      SEG_0:     dec.code = 4'd0;
      SEG_1:     dec.code = 4'd1;
      SEG_2:     dec.code = 4'd2;
      SEG_3:     dec.code = 4'd3;
      SEG_4:     dec.code = 4'd4;
      SEG_5:     dec.code = 4'd5;
      SEG_6:     dec.code = 4'd6;
      SEG_7:     dec.code = 4'd7;
`ifdef SEG7_HEX_EN
      SEG_8:     dec.code = 4'd8;
      SEG_9:     dec.code = 4'd9;
      SEG_A:     dec.code = 4'd10;
      SEG_B:     dec.code = 4'd11;
      SEG_C:     dec.code = 4'd12;
      SEG_D:     dec.code = 4'd13;
      SEG_E:     dec.code = 4'd14;
      SEG_F:     dec.code = 4'd15;
`endif
      default:   dec.err  = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      prev  <= '1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      prev  <= cur;
    end
  end

  // A locked digit stays silent until its inputs move; any change restarts the run at 1
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (!sel_valid) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
    end else if (state == ST_LOCKED && same) begin
      state_n = ST_LOCKED;
    end else begin
      cnt_n   = (state == ST_COUNT && same) ? cnt + 8'd1 : 8'd1;
      state_n = (cnt_n == 8'(STABLE_CYC)) ? ST_LOCKED : ST_COUNT;
    end
  end

  always_comb begin
    accept = (state_n == ST_LOCKED) && !(state == ST_LOCKED && same);
    push   = accept && (dec != shadow[sel_idx]);
    pop    = ev.ev_valid && ev.ev_ready;
    ev_in  = {sel_idx, dec};
  end

  // The shadow follows every accepted change even when the FIFO must drop it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_DIG; i++) shadow[i] <= '0;
      ovf <= 1'b0;
    end else begin
      if (push) shadow[sel_idx] <= dec;
      if (push && full && !pop) ovf <= 1'b1;
    end
  end

  seg7_evfifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EV_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (ev_in),
    .pop   (pop),
    .dout  (ev_out),
    .valid (ev.ev_valid),
    .full  (full)
  );

  assign ev.ev_idx  = ev_out.idx;
  assign ev.ev_on   = ev_out.d.on;
  assign ev.ev_code = ev_out.d.code;
  assign ev.ev_err  = ev_out.d.err;

endmodule

// File: tb/tb_seg7_sniffer.sv
// Self-checking bench for seg7_sniffer: directed table, corner sequences, random vs run-length model.
module tb_seg7_sniffer;

  localparam int NDIG   = 8;
  localparam int STABLE = 4;
  localparam int DEPTH  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [6:0]      seg_n;
  logic [NDIG-1:0] an_n;
  logic            ovf;

  seg7_sniffer_if evif();

  seg7_sniffer #(
    .NDIG       (NDIG),
    .STABLE_CYC (STABLE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .seg_n (seg_n),
    .an_n  (an_n),
    .ev    (evif),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int on;
    int code;
    int err;
  } mev_t;

  typedef struct {
    logic [6:0] seg;
    logic [7:0] an;
    bit         expEv;
    int         idx;
    int         on;
    int         code;
    int         err;
  } vec_t;

  logic [6:0] pat [16];
  int         nLegal;
  mev_t       q[$];
  int         shOn [8];
  int         shCode [8];
  int         shErr [8];
  int         run;
  logic       lastSel;
  logic [6:0] lastSeg;
  logic [7:0] lastAn;
  int         mOvf;
  int         checks = 0;
  int         fails = 0;
  vec_t       vecs [7];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic decodeModel(input logic [6:0] s, output int on, output int code, output int err);
    on = 1; code = 0; err = 1;
    if (s == 7'b1111111) begin
      on = 0; err = 0;
    end else begin
      for (int i = 0; i < nLegal; i++) begin
        if (pat[i] == s) begin
          code = i; err = 0;
        end
      end
    end
  endtask

  task automatic modelReset();
    q.delete();
    run = 0; lastSel = 1'b0; lastSeg = '1; lastAn = '1; mOvf = 0;
    for (int i = 0; i < 8; i++) begin
      shOn[i] = 0; shCode[i] = 0; shErr[i] = 0;
    end
  endtask

  // Accept exactly when an uninterrupted run of one valid selection reaches STABLE cycles
  task automatic modelStep();
    int   n = 0;
    int   idx = 0;
    bit   sel, pop, pushIt;
    mev_t e;
    for (int i = 0; i < NDIG; i++) begin
      if (!an_n[i]) begin n++; idx = i; end
    end
    sel = (n == 1);
    if (sel && lastSel && seg_n == lastSeg && an_n == lastAn) run++;
    else run = sel ? 1 : 0;
    lastSel = sel; lastSeg = seg_n; lastAn = an_n;
    pop = evif.ev_ready && (q.size() > 0);
    pushIt = 0;
    if (sel && run == STABLE) begin
      decodeModel(seg_n, e.on, e.code, e.err);
      e.idx = idx;
      if (e.on != shOn[idx] || e.code != shCode[idx] || e.err != shErr[idx]) begin
        shOn[idx] = e.on; shCode[idx] = e.code; shErr[idx] = e.err;
        if (q.size() < DEPTH || pop) pushIt = 1;
        else mOvf = 1;
      end
    end
    if (pop) void'(q.pop_front());
    if (pushIt) q.push_back(e);
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".ev_valid"}, evif.ev_valid, (q.size() > 0) ? 1 : 0);
    if (q.size() > 0) begin
      check({tag, ".ev_idx"},  evif.ev_idx,  q[0].idx);
      check({tag, ".ev_on"},   evif.ev_on,   q[0].on);
      check({tag, ".ev_code"}, evif.ev_code, q[0].code);
      check({tag, ".ev_err"},  evif.ev_err,  q[0].err);
    end
    check({tag, ".ovf"}, ovf, mOvf);
  endtask

  task automatic applyStimulus(input logic [6:0] s, input logic [7:0] a, input logic r, input string tag);
    seg_n = s; an_n = a; evif.ev_ready = r;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput(tag);
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    modelReset();
    #1;
    check({tag, ".ev_valid"}, evif.ev_valid, 0);
    check({tag, ".ev_idx"},   evif.ev_idx,   0);
    check({tag, ".ev_on"},    evif.ev_on,    0);
    check({tag, ".ev_code"},  evif.ev_code,  0);
    check({tag, ".ev_err"},   evif.ev_err,   0);
    check({tag, ".ovf"},      ovf,           0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int   seen;
    logic [7:0] a;
    logic [6:0] s;
    logic r;

    pat[0]  = 7'b0000001; pat[1]  = 7'b1001111; pat[2]  = 7'b0010010; pat[3]  = 7'b0000110;
    pat[4]  = 7'b1001100; pat[5]  = 7'b0100100; pat[6]  = 7'b0100000; pat[7]  = 7'b0001111;
    pat[8]  = 7'b0000000; pat[9]  = 7'b0000100; pat[10] = 7'b0001000; pat[11] = 7'b1100000;
    pat[12] = 7'b0110001; pat[13] = 7'b1000010; pat[14] = 7'b0110000; pat[15] = 7'b0111000;
`ifdef SEG7_HEX_EN
    nLegal = 16;
`else
    nLegal = 8;
`endif

    vecs[0] = '{seg: 7'b1111110, an: 8'b11111101, expEv: 1, idx: 1, on: 1, code: 0, err: 1};
    vecs[1] = '{seg: 7'b1001111, an: 8'b11111101, expEv: 1, idx: 1, on: 1, code: 1, err: 0};
`ifdef SEG7_HEX_EN
    vecs[2] = '{seg: 7'b0000000, an: 8'b11111101, expEv: 1, idx: 1, on: 1, code: 8, err: 0};
`else
    vecs[2] = '{seg: 7'b0000000, an: 8'b11111101, expEv: 1, idx: 1, on: 1, code: 0, err: 1};
`endif
    vecs[3] = '{seg: 7'b1111111, an: 8'b11111101, expEv: 1, idx: 1, on: 0, code: 0, err: 0};
    vecs[4] = '{seg: 7'b1111111, an: 8'b11011111, expEv: 0, idx: 0, on: 0, code: 0, err: 0};
    vecs[5] = '{seg: 7'b0000110, an: 8'b01111111, expEv: 1, idx: 7, on: 1, code: 3, err: 0};
    vecs[6] = '{seg: 7'b0000110, an: 8'b01111111, expEv: 0, idx: 0, on: 0, code: 0, err: 0};

    rst = 1'b1; seg_n = 7'h7F; an_n = 8'hFF; evif.ev_ready = 1'b0;
    modelReset();
    #1;
    check("por.ev_valid", evif.ev_valid, 0);
    check("por.ovf", ovf, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] digit 0 shows 2, held four cycles");
    for (int c = 1; c <= 4; c++) begin
      applyStimulus(7'b0010010, 8'b11111110, 1'b1, "hold2");
      check("hold2.latency", evif.ev_valid, (c == 4) ? 1 : 0);
    end
    check("hold2.idx", evif.ev_idx, 0);
    check("hold2.on", evif.ev_on, 1);
    check("hold2.code", evif.ev_code, 2);
    check("hold2.err", evif.ev_err, 0);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(7'b0010010, 8'b11111110, 1'b1, "steady");
      if (evif.ev_valid) seen++;
    end
    check("steady.no_events", seen, 0);

    $display("[TB] digit 2 toggling, then held");
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      applyStimulus(((c / 2) % 2 == 1) ? 7'b0000110 : 7'b0100100, 8'b11111011, 1'b1, "toggle");
      if (evif.ev_valid) seen++;
    end
    check("toggle.no_events", seen, 0);
    for (int c = 0; c < 4; c++) applyStimulus(7'b1001111, 8'b11111011, 1'b1, "toggle_hold");
    check("toggle_hold.valid", evif.ev_valid, 1);
    check("toggle_hold.idx", evif.ev_idx, 2);
    check("toggle_hold.code", evif.ev_code, 1);
    applyStimulus(7'h7F, 8'hFF, 1'b1, "toggle_pop");

    $display("[TB] five changes with consumer stalled");
    for (int d = 0; d < 5; d++) begin
      a = ~(8'b1 << d);
      for (int c = 0; c < 4; c++) applyStimulus(pat[d + 3], a, 1'b0, "stall");
      if (d == 3) check("stall.full_no_ovf", ovf, 0);
    end
    check("stall.ovf", ovf, 1);
    for (int k = 0; k < 4; k++) begin
      check("drain.valid", evif.ev_valid, 1);
      check("drain.idx", evif.ev_idx, k);
      check("drain.code", evif.ev_code, k + 3);
      applyStimulus(7'h7F, 8'hFF, 1'b1, "drain");
    end
    check("drain.empty", evif.ev_valid, 0);
    check("drain.ovf_sticky", ovf, 1);

    $display("[TB] decode table vectors");
    for (int v = 0; v < 7; v++) begin
      for (int c = 0; c < STABLE; c++) applyStimulus(vecs[v].seg, vecs[v].an, 1'b0, "vec");
      check($sformatf("vec%0d.valid", v), evif.ev_valid, vecs[v].expEv ? 1 : 0);
      if (vecs[v].expEv) begin
        check($sformatf("vec%0d.idx", v),  evif.ev_idx,  vecs[v].idx);
        check($sformatf("vec%0d.on", v),   evif.ev_on,   vecs[v].on);
        check($sformatf("vec%0d.code", v), evif.ev_code, vecs[v].code);
        check($sformatf("vec%0d.err", v),  evif.ev_err,  vecs[v].err);
      end
      applyStimulus(7'h7F, 8'hFF, 1'b1, "vec_pop");
    end

    $display("[TB] reset in the middle of a stability count");
    for (int c = 0; c < 3; c++) applyStimulus(7'b1001100, 8'b10111111, 1'b1, "prereset");
    check("prereset.valid", evif.ev_valid, 0);
    doReset("midreset");
    for (int c = 1; c <= 4; c++) begin
      applyStimulus(7'b1001100, 8'b10111111, 1'b0, "postreset");
      check("postreset.latency", evif.ev_valid, (c == 4) ? 1 : 0);
    end
    check("postreset.idx", evif.ev_idx, 6);
    check("postreset.code", evif.ev_code, 4);

    $display("[TB] randomized runs against the model");
    for (int n = 0; n < 80; n++) begin
      int sa = $urandom_range(0, 9);
      int ss = $urandom_range(0, 9);
      int len = $urandom_range(1, 7);
      if (sa < 8) a = ~(8'b1 << sa);
      else if (sa == 8) a = 8'hFF;
      else begin
        int b1 = $urandom_range(0, 7);
        int b2 = (b1 + 1 + $urandom_range(0, 6)) % 8;
        a = ~((8'b1 << b1) | (8'b1 << b2));
      end
      if (ss < 8) s = pat[$urandom_range(0, 15)];
      else if (ss == 8) s = 7'h7F;
      else s = 7'($urandom);
      for (int c = 0; c < len; c++) begin
        r = ($urandom_range(0, 3) != 0);
        applyStimulus(s, a, r, "rand");
      end
    end
    for (int c = 0; c < 8; c++) applyStimulus(7'h7F, 8'hFF, 1'b1, "flush");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
